// File: rtl/delay_line_var.sv
// -----------------------------------------------------------------------------
// delay_line_var
//   Runtime-programmable balancing delay for a video stream and its sync
//   sideband. Data and syncs move through MAX_DELAY clock-enabled stages. The
//   output tap is chosen by a registered copy of the requested depth. A fill
//   counter blanks the output until the selected tap holds data that entered
//   after the last depth change. This prevents stale or partial syncs from
//   leaking downstream.
//
// Parameters
//   N          data width
//   SYNC_W     sideband width (de, hsync, vsync)
//   MAX_DELAY  number of stages, >= 1
//   DLY_W      width of the delay port; 2**DLY_W > MAX_DELAY
//
// Ports
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   ce       in   clock enable; stages and fill counter advance only when 1
//   delay    in   requested depth in ce-cycles (values above MAX_DELAY clamp)
//   d        in   input data
//   d_sync   in   input sideband
//   q        out  delayed data, 0 while not valid
//   q_sync   out  delayed sideband, 0 while not valid
//   q_valid  out  the selected tap is fully primed for the current depth
//   cfg_err  out  registered flag: requested depth exceeds MAX_DELAY
// -----------------------------------------------------------------------------

// One clock-enabled storage stage of the delay chain.
//   clk_i, rst_ni  clock / async active-low reset
//   ce_i           load enable
//   d_i            value from the previous stage (or the stream input)
//   q_o            registered stage contents
module dlv_stage #(
    parameter int W = 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         ce_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] data_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q <= '0;
        end else if (ce_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

module delay_line_var #(
    parameter int N         = 24,
    parameter int SYNC_W    = 3,
    parameter int MAX_DELAY = 16,
    parameter int DLY_W     = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ce,
    input  logic [DLY_W-1:0]  delay,
    input  logic [N-1:0]      d,
    input  logic [SYNC_W-1:0] d_sync,
    output logic [N-1:0]      q,
    output logic [SYNC_W-1:0] q_sync,
    output logic              q_valid,
    output logic              cfg_err
);

    localparam int               W    = N + SYNC_W;
    localparam logic [DLY_W-1:0] MAXD = DLY_W'(MAX_DELAY);

    // -------------------------------------------------------------------------
    // Storage chain. Stage k holds the sample taken k+1 ce-edges ago.
    // -------------------------------------------------------------------------
    logic [MAX_DELAY-1:0][W-1:0] stage_in;
    logic [MAX_DELAY-1:0][W-1:0] stage_q;

    genvar g;
    generate
        for (g = 0; g < MAX_DELAY; g++) begin : g_stage
            if (g == 0) begin : g_head
                assign stage_in[g] = {d, d_sync};
            end else begin : g_link
                assign stage_in[g] = stage_q[g-1];
            end

            dlv_stage #(
                .W (W)
            ) u_stage (
                .clk_i  (clk),
                .rst_ni (rst_n),
                .ce_i   (ce),
                .d_i    (stage_in[g]),
                .q_o    (stage_q[g])
            );
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Depth register, config error flag and fill counter.
    // The depth register and error flag track the config input on every
    // edge, whether or not ce is set. This lets a config write take effect
    // while the stream is stalled.
    // -------------------------------------------------------------------------
    logic [DLY_W-1:0] delay_r_q, delay_r_d;
    logic [DLY_W-1:0] cnt_q,     cnt_d;
    logic             cfg_err_q, cfg_err_d;

    always_comb begin
        cfg_err_d = (delay > MAXD);
        delay_r_d = cfg_err_d ? MAXD : delay;
        cnt_d     = cnt_q;
        // Any change of the effective depth forces a re-prime, including a
        // change back to an earlier value. Older samples in the chain were
        // never qualified for the new tap.
        if (delay_r_d != delay_r_q) begin
            cnt_d = '0;
        end else if (ce && (cnt_q < MAXD)) begin
            cnt_d = cnt_q + DLY_W'(1);
        end
    end

    // Reset parks the depth at MAX_DELAY. The first edge after release then
    // normally sees a depth change, and priming starts from that edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            delay_r_q <= MAXD;
            cnt_q     <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            delay_r_q <= delay_r_d;
            cnt_q     <= cnt_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    // -------------------------------------------------------------------------
    // Output tap select and blanking. Depth 0 is a pure combinational
    // passthrough of the live input.
    // -------------------------------------------------------------------------
    logic [W-1:0] raw;
    logic [W-1:0] out;
    logic         valid;

    always_comb begin
        raw = {d, d_sync};
        for (int k = 0; k < MAX_DELAY; k++) begin
            if (delay_r_q == DLY_W'(k + 1)) begin
                raw = stage_q[k];
            end
        end
    end

    assign valid = (cnt_q >= delay_r_q);
    assign out   = valid ? raw : '0;

    assign {q, q_sync} = out;
    assign q_valid     = valid;
    assign cfg_err     = cfg_err_q;

endmodule

// File: doc/delay_line_var.md
Name: delay_line_var

Overview:
Runtime-programmable pipeline delay for video-stream data plus sync sideband (de/hsync/vsync). It generalises the fixed-depth delay line with four additions: clock enable, runtime-selectable depth, fill/valid tracking and output blanking. It sits between processing stages with unequal latency, such as colour-space conversion vs. passthrough sync, where the balancing delay is set from a config register.

Parameters:
N, 24, data width in bits
SYNC_W, 3, sideband width (de, hsync, vsync)
MAX_DELAY, 16, maximum depth in ce-cycles; must be at least 1
DLY_W, 5, width of delay port; 2^DLY_W must exceed MAX_DELAY

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
ce  in  1  clock enable; state advances only when ce=1
delay  in  DLY_W  requested delay in ce-cycles, 0..MAX_DELAY
d  in  N  input data
d_sync  in  SYNC_W  input sideband
q  out  N  delayed data; 0 when q_valid=0
q_sync  out  SYNC_W  delayed sideband; 0 when q_valid=0
q_valid  out  1  delayed output is fully primed for current delay
cfg_err  out  1  registered; 1 while requested delay > MAX_DELAY

Behaviour:
- Storage model: MAX_DELAY stages of {d, d_sync}.
  - On a clk edge with ce=1: stage[0] <= {d, d_sync}; stage[k] <= stage[k-1].
  - ce=0: all stages hold.
  - Implementation may be a shift chain or a circular buffer; observable behaviour must match the shift model.
- Effective delay:
  - del_c = min(delay, MAX_DELAY).
  - Registered copy delay_r is updated every edge, independent of ce.
  - cfg_err <= (delay > MAX_DELAY) every edge.
- Output select (combinational from registers):
  - delay_r=0: raw = {d, d_sync}, pure combinational passthrough.
  - Otherwise: raw = stage[delay_r-1].
- Fill counter cnt, range 0..MAX_DELAY, saturating:
  - If del_c != delay_r at an edge: cnt <= 0. The data shift still occurs if ce=1.
  - Else if ce=1 and cnt < MAX_DELAY: cnt <= cnt+1.
  - Else: hold.
- q_valid = (cnt >= delay_r).
- {q, q_sync} = q_valid ? raw : 0. Blanking prevents spurious syncs after a depth change.
- Reset (rst_n low, asynchronous):
  - All stages 0, cnt=0, delay_r=MAX_DELAY, cfg_err=0.
  - Hence q_valid=0, q=0, q_sync=0 immediately on assertion, without a clock.
- Reset release: synchronous to clk. The first edge after release loads delay_r.
- Latency: once primed with delay_r=D>0, q at the output after ce-edge t equals the d sampled at ce-edge t-D+1. That is, D ce-edges of delay, counting only ce=1 edges.
- Simultaneous depth change and ce: data shifts, cnt=0, q_valid drops the cycle after the edge.
- Changing depth back to the previous value still re-primes. No shortcut.
- Reset mid-operation: all content lost; priming restarts.

Test Plan:
- Priming (N=8, MAX_DELAY=16): reset, delay=4, ce=1, d=1,2,3,... on successive edges -> q_valid=0 after edges 1-4; after edge 5 q_valid=1, q=2; after edge 6 q=3.
- Clock enable: primed at delay=4, toggle ce 1,0,0,1 -> q and q_valid frozen through the ce=0 cycles; sequence resumes without skips or repeats; cnt unchanged.
- Depth 0 passthrough: delay=0 -> q_valid=1 one edge after the change; q tracks d combinationally within the same cycle, including when ce=0.
- Runtime change: primed at delay=4, set delay=8 -> q=0 and q_sync=0 with q_valid=0 for 8 ce-edges after the change edge; then q = d from 8 ce-edges earlier.
- Out-of-range and saturation: delay=20 -> cfg_err=1 after one edge; behaves as delay 16 (q_valid after 16 ce-edges). Set delay=16 -> cfg_err=0 and no re-prime, because del_c is unchanged. Run 100 ce-edges -> cnt stays 16.
- Async reset: assert rst_n=0 mid-stream between edges -> q=0, q_sync=0, q_valid=0 immediately; after release the priming sequence repeats exactly as in the first scenario.
